// File: rtl/cpu_prog_loader_if.sv
// Boot stream and memory backdoor bundle between the host feeder and
// the program loader.
interface cpu_prog_loader_if #(
    parameter int pDATA_WIDTH = 8,
    parameter int pADDR_WIDTH = 8
);
    logic                   ivalid;
    logic [pDATA_WIDTH-1:0] idata;
    logic                   oready;
    logic                   omem_we;
    logic [pADDR_WIDTH-1:0] omem_addr;
    logic [pDATA_WIDTH-1:0] omem_data;

    modport master (
        output ivalid,
        output idata,
        input  oready,
        input  omem_we,
        input  omem_addr,
        input  omem_data
    );

    modport slave (
        input  ivalid,
        input  idata,
        output oready,
        output omem_we,
        output omem_addr,
        output omem_data
    );
endinterface

// File: rtl/cpu_prog_loader.sv
// Boot loader: parses framed bytes, backdoor-writes the payload and
// releases the CPU once the frame checksum matches.
module cpu_prog_loader #(
    parameter int pDATA_WIDTH = 8,
    parameter int pADDR_WIDTH = 8
) (
    input  logic             iclk,
    input  logic             irst,
    cpu_prog_loader_if.slave bus,
    output logic             ocpu_rst_n,
    output logic             ocpu_en,
    output logic             obusy,
    output logic             odone,
    output logic             oerr
);
    localparam int RW = pADDR_WIDTH + 1;
    localparam logic [pDATA_WIDTH-1:0] HDR = pDATA_WIDTH'(8'hA5);
    localparam logic [RW-1:0] FULL = RW'(1) << pADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE, ADDR, LEN, DATA, CSUM, RUN, ERR
    } state_t;

    state_t                 state;
    logic                   ready;
    logic                   mem_we;
    logic [pADDR_WIDTH-1:0] mem_addr;
    logic [pDATA_WIDTH-1:0] mem_data;
    logic [pADDR_WIDTH-1:0] addr;
    logic [RW-1:0]          rem;
    logic [pDATA_WIDTH-1:0] sum;
    logic [pADDR_WIDTH-1:0] len;
    logic                   take;
    logic                   hdr;

    assign take = bus.ivalid & ready;
    assign hdr  = take && (bus.idata == HDR);
    assign len  = pADDR_WIDTH'(bus.idata);

    assign bus.oready    = ready;
    assign bus.omem_we   = mem_we;
    assign bus.omem_addr = mem_addr;
    assign bus.omem_data = mem_data;

    always_ff @(posedge iclk) begin
        if (irst) begin
            state      <= IDLE;
            ready      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            addr       <= '0;
            rem        <= '0;
            sum        <= '0;
            ocpu_rst_n <= 1'b0;
            ocpu_en    <= 1'b0;
            obusy      <= 1'b0;
            odone      <= 1'b0;
            oerr       <= 1'b0;
        end else begin
            ready  <= 1'b1;
            mem_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hdr) begin
                        state <= ADDR;
                        obusy <= 1'b1;
                    end
                end
                ADDR: begin
                    if (take) begin
                        addr  <= pADDR_WIDTH'(bus.idata);
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (take) begin
                        // a zero length means the whole address space
                        rem   <= (len == '0) ? FULL : {1'b0, len};
                        sum   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (take) begin
                        mem_we   <= 1'b1;
                        mem_addr <= addr;
                        mem_data <= bus.idata;
                        addr     <= addr + pADDR_WIDTH'(1);
                        sum      <= sum + bus.idata;
                        rem      <= rem - RW'(1);
                        if (rem == RW'(1)) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (take) begin
                        obusy <= 1'b0;
                        if (bus.idata == sum) begin
                            state      <= RUN;
                            odone      <= 1'b1;
                            ocpu_rst_n <= 1'b1;
                        end else begin
                            state <= ERR;
                            oerr  <= 1'b1;
                        end
                    end
                end
                RUN, ERR: begin
                    if (hdr) begin
                        state      <= ADDR;
                        obusy      <= 1'b1;
                        odone      <= 1'b0;
                        oerr       <= 1'b0;
                        ocpu_rst_n <= 1'b0;
                        ocpu_en    <= 1'b0;
                    end else if (ocpu_rst_n) begin
                        // enable trails reset release by one clock
                        ocpu_en <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cpu_prog_loader.md
Name: cpu_prog_loader

Overview:
Upstream boot stage for cpu_top. It receives a framed byte stream over a valid/ready handshake and writes the payload into the CPU memory array through the memory backdoor write port. While loading, it holds the CPU in reset and disabled. After a frame passes its checksum, it releases the CPU by driving its reset and enable inputs.

Parameters:
pDATA_WIDTH, 8, width of stream bytes and memory words
pADDR_WIDTH, 8, memory address width; address space is 2**pADDR_WIDTH words

Ports:
iclk  input  1  clock
irst  input  1  reset; one clock, reset is synchronous and active-high
ivalid  input  1  stream byte valid
idata  input  pDATA_WIDTH  stream byte
oready  output  1  loader can accept a byte
omem_we  output  1  memory backdoor write strobe, one cycle per word
omem_addr  output  pADDR_WIDTH  memory write address
omem_data  output  pDATA_WIDTH  memory write data
ocpu_rst_n  output  1  drives cpu_top irst_n; low holds the CPU in reset
ocpu_en  output  1  drives cpu_top ien
obusy  output  1  frame in progress
odone  output  1  last frame loaded and checksum good (sticky)
oerr  output  1  last frame failed its checksum (sticky)

Behaviour:
- Handshake: a byte is accepted on a rising edge when ivalid & oready. oready=1 in every state except reset.
- Frame format: header 0xA5, start address, length L (0 means 2**pADDR_WIDTH words), L data bytes, checksum.
- Checksum: the 8-bit sum, mod 256, of all data bytes. Header, address and length are not included.
- FSM states: IDLE, ADDR, LEN, DATA, CSUM, RUN, ERR.
- IDLE: an accepted 0xA5 goes to ADDR. Any other byte is discarded and the state stays IDLE.
- ADDR: an accepted byte loads the address counter, then goes to LEN.
- LEN: an accepted byte loads the remaining-word counter (0 loads 2**pADDR_WIDTH), clears the running sum, then goes to DATA.
- DATA, per accepted byte:
  - The next cycle, registered: omem_we=1, omem_addr=current address, omem_data=byte. The write latency is one cycle.
  - The address increments and wraps from 2**pADDR_WIDTH-1 to 0.
  - The sum accumulates.
  - The remaining-word counter decrements; when it reaches 0, go to CSUM.
- CSUM: an accepted byte equal to the sum goes to RUN and sets odone=1. A mismatch goes to ERR and sets oerr=1.
- RUN: ocpu_rst_n=1 on entry. ocpu_en=1 from the cycle after ocpu_rst_n rises. This gives the CPU one clean clock out of reset before it is enabled.
- RUN and ERR: an accepted 0xA5 starts a new frame and goes to ADDR. In the same edge: odone=0, oerr=0, ocpu_rst_n=0, ocpu_en=0. Other bytes are discarded.
- ERR: the CPU stays held (ocpu_rst_n=0, ocpu_en=0).
- obusy=1 in ADDR, LEN, DATA and CSUM.
- omem_we is 0 in every cycle except the one-cycle write strobes. The header, address, length and checksum bytes never write.
- Gaps in ivalid are tolerated anywhere; the state is held.
- Reset, including mid-frame, returns to IDLE. Reset values: oready=0 during reset then 1, omem_we=0, omem_addr=0, omem_data=0, ocpu_rst_n=0, ocpu_en=0, obusy=0, odone=0, oerr=0. The partial frame is abandoned; words already written stay in memory.
- Reset has priority over an accepted byte in the same cycle.

Test Plan:
- Stream A5,10,03,01,02,03,06 back-to-back -> memory writes (0x10,01),(0x11,02),(0x12,03) on consecutive cycles, each one cycle after acceptance. odone=1, ocpu_rst_n rises, ocpu_en rises one cycle later.
- Stream A5,FE,03,11,22,33,66 -> writes to addresses FE, FF, 00 (address wraps). odone=1.
- Stream A5,00,02,05,05,0B (correct sum 0x0A) -> oerr=1, odone=0, ocpu_rst_n=0, ocpu_en=0. Then resend A5,00,02,05,05,0A -> oerr=0, odone=1.
- Stream 00,FF,A5,20,01,7E,7E with ivalid=0 for 3 cycles between each byte -> the leading 00 and FF are ignored, exactly one write (0x20,7E), odone=1, no extra omem_we pulses.
- Length byte 00 -> 256 data bytes are written to consecutive wrapped addresses, and the checksum is accepted only after the 256th byte.
- Assert irst after the 2nd data byte of a 4-byte frame -> state returns to IDLE, all outputs are at reset values, and a following complete frame loads correctly.
